// File: rtl/calc_entry.sv
// -----------------------------------------------------------------------------
// calc_entry: keypad entry controller for the calculator datapath.
//
// Takes one-cycle key strobes and builds two 4-digit BCD operands (save1,
// save2) and an operation code (op). It drives the display selector, pulses
// calc_go to the arithmetic unit on equals, and waits for calc_done before it
// shows the result.
//
// Optional feature macro: CALC_ENTRY_TIMEOUT_EN
//   defined   : a WAIT_RES watchdog. After TIMEOUT_CYCLES cycles without
//               calc_done it sets err and moves on to SHOW_RES.
//   undefined : there is no counter, err stays 0, and WAIT_RES waits
//               indefinitely.
//
// Handshake: key_valid and calc_done are single-cycle strobes with no
// back-pressure. A strobe is consumed on the rising edge that samples it high.
// key_code is meaningful only while key_valid is high. calc_go is a
// single-cycle strobe; the consumer must take it on the cycle it is high.
//
// Ports:
//   clk, rst       : clock; synchronous active-high reset
//   key_valid      : key strobe
//   key_code[3:0]  : 0-9 digit, A-D op, E equals, F clear
//   calc_done      : result-ready strobe from the arithmetic unit
//   save1[15:0]    : operand A (4 BCD digits, most significant nibble first)
//   save2[15:0]    : operand B
//   op[3:0]        : last op key (A-D), 0 when none
//   display_state  : 00 save1, 01 op, 10 save2, 11 result
//   calc_go        : start pulse to the arithmetic unit
//   err            : timeout error flag
//   dbg_state[2:0] : current FSM state, for observation
// -----------------------------------------------------------------------------
module calc_entry #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        calc_done,
  output logic [15:0] save1,
  output logic [15:0] save2,
  output logic [3:0]  op,
  output logic [1:0]  display_state,
  output logic        calc_go,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_ENTRY1   = 3'd0,
    S_OPSEL    = 3'd1,
    S_ENTRY2   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_SHOW_RES = 3'd4
  } state_t;

  // A zero or negative watchdog length is meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("calc_entry: TIMEOUT_CYCLES must be >= 1");
  end

  state_t      state_q, state_d;
  logic [15:0] save1_q, save1_d;
  logic [15:0] save2_q, save2_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  cnt1_q, cnt1_d;
  logic [2:0]  cnt2_q, cnt2_d;
  logic [1:0]  disp_q, disp_d;
  logic        go_q, go_d;
  logic        err_q, err_d;

`ifdef CALC_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  logic key_clear, key_digit, key_op, key_eq;

  always_comb begin
    key_clear = key_valid && (key_code == 4'hF);
    key_digit = key_valid && (key_code <= 4'h9);
    key_op    = key_valid && (key_code >= 4'hA) && (key_code <= 4'hD);
    key_eq    = key_valid && (key_code == 4'hE);
  end

  always_comb begin
    state_d = state_q;
    save1_d = save1_q;
    save2_d = save2_q;
    op_d    = op_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    go_d    = 1'b0;
    err_d   = err_q;
`ifdef CALC_ENTRY_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    if (key_clear) begin
      // Clear overrides everything, including a coincident calc_done.
      state_d = S_ENTRY1;
      save1_d = 16'h0000;
      save2_d = 16'h0000;
      op_d    = 4'h0;
      cnt1_d  = 3'd0;
      cnt2_d  = 3'd0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_ENTRY1: begin
          if (key_digit) begin
            // Once four digits are in, further digits are dropped.
            if (cnt1_q < 3'd4) begin
              save1_d = {save1_q[11:0], key_code};
              cnt1_d  = cnt1_q + 3'd1;
            end
          end else if (key_op) begin
            op_d    = key_code;
            state_d = S_OPSEL;
          end
        end
        S_OPSEL: begin
          if (key_op) begin
            op_d = key_code;
          end else if (key_digit) begin
            save2_d = {12'h000, key_code};
            cnt2_d  = 3'd1;
            state_d = S_ENTRY2;
          end
        end
        S_ENTRY2: begin
          if (key_digit) begin
            if (cnt2_q < 3'd4) begin
              save2_d = {save2_q[11:0], key_code};
              cnt2_d  = cnt2_q + 3'd1;
            end
          end else if (key_eq) begin
            go_d    = 1'b1;
            state_d = S_WAIT_RES;
`ifdef CALC_ENTRY_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
        S_WAIT_RES: begin
          // calc_done is checked first, so it wins on the timeout cycle.
          if (calc_done) begin
            state_d = S_SHOW_RES;
`ifdef CALC_ENTRY_TIMEOUT_EN
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = S_SHOW_RES;
          end else begin
            tmo_d = tmo_q + TW'(1);
`endif
          end
        end
        S_SHOW_RES: begin
          if (key_digit) begin
            save1_d = {12'h000, key_code};
            save2_d = 16'h0000;
            op_d    = 4'h0;
            cnt1_d  = 3'd1;
            cnt2_d  = 3'd0;
            err_d   = 1'b0;
            state_d = S_ENTRY1;
          end
        end
        default: state_d = S_ENTRY1;
      endcase
    end

    // The selector is taken from the next state, so it changes on the same
    // edge as the state.
    case (state_d)
      S_ENTRY1:   disp_d = 2'b00;
      S_OPSEL:    disp_d = 2'b01;
      S_ENTRY2,
      S_WAIT_RES: disp_d = 2'b10;
      S_SHOW_RES: disp_d = 2'b11;
      default:    disp_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ENTRY1;
      save1_q <= 16'h0000;
      save2_q <= 16'h0000;
      op_q    <= 4'h0;
      cnt1_q  <= 3'd0;
      cnt2_q  <= 3'd0;
      disp_q  <= 2'b00;
      go_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef CALC_ENTRY_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      save1_q <= save1_d;
      save2_q <= save2_d;
      op_q    <= op_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      disp_q  <= disp_d;
      go_q    <= go_d;
      err_q   <= err_d;
`ifdef CALC_ENTRY_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign save1         = save1_q;
  assign save2         = save2_q;
  assign op            = op_q;
  assign display_state = disp_q;
  assign calc_go       = go_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_calc_entry.sv
// -----------------------------------------------------------------------------
// tb_calc_entry: directed bench for calc_entry.
// Inputs are driven on the falling edge and outputs are checked on the
// following falling edge, half a cycle after the rising edge.
// -----------------------------------------------------------------------------
module tb_calc_entry;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        calc_done;
  logic [15:0] save1;
  logic [15:0] save2;
  logic [3:0]  op;
  logic [1:0]  display_state;
  logic        calc_go;
  logic        err;
  logic [2:0]  dbg_state;

  int n_cmp;
  int n_bad;
  logic [1:0] exp_q[$];

  calc_entry #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .calc_done    (calc_done),
    .save1        (save1),
    .save2        (save2),
    .op           (op),
    .display_state(display_state),
    .calc_go      (calc_go),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks; all are called at a falling edge and return at one
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Consecutive calls give back-to-back strobes.
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pulse_done();
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_save1"}, 32'(save1), 32'h0);
    chk({tag, "_save2"}, 32'(save2), 32'h0);
    chk({tag, "_op"},    32'(op), 32'h0);
    chk({tag, "_ds"},    32'(display_state), 32'h0);
    chk({tag, "_go"},    32'(calc_go), 32'h0);
    chk({tag, "_err"},   32'(err), 32'h0);
    chk({tag, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  task automatic chk_ds(input string tag);
    logic [1:0] e;
    e = exp_q.pop_front();
    chk(tag, 32'(display_state), 32'(e));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    calc_done = 1'b0;
    idle(3);
    rst = 1'b0;
    chk_all_zero("reset");

    // entry and operation: 1 2 3 A 4 5 E
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    press(4'h1);
    chk("e1_save1", 32'(save1), 32'h0001);
    press(4'h2);
    press(4'h3);
    chk("e1_save1b", 32'(save1), 32'h0123);
    chk_ds("e1_ds00");
    press(4'hA);
    chk("e1_op", 32'(op), 32'hA);
    chk_ds("e1_ds01");
    press(4'h4);
    chk("e1_save2a", 32'(save2), 32'h0004);
    chk_ds("e1_ds10");
    press(4'h5);
    chk("e1_save2b", 32'(save2), 32'h0045);
    chk("e1_go_pre", 32'(calc_go), 32'h0);
    press(4'hE);
    chk("e1_go", 32'(calc_go), 32'h1);
    chk("e1_state_wait", 32'(dbg_state), 32'h3);
    chk("e1_ds_wait", 32'(display_state), 32'h2);
    idle(1);
    chk("e1_go_off", 32'(calc_go), 32'h0);

    // result and restart
    pulse_done();
    chk("res_ds", 32'(display_state), 32'h3);
    chk("res_state", 32'(dbg_state), 32'h4);
    press(4'hA);
    press(4'hE);
    chk("res_ignore_keys", 32'(dbg_state), 32'h4);
    press(4'h3);
    chk("rst_save1", 32'(save1), 32'h0003);
    chk("rst_save2", 32'(save2), 32'h0000);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_ds", 32'(display_state), 32'h0);
    pulse_done();
    chk("done_outside_wait", 32'(dbg_state), 32'h0);
    press(4'h4);
    chk("restart_append", 32'(save1), 32'h0034);

    // digit saturation, back-to-back strobes
    press(4'hF);
    chk_all_zero("clr1");
    press(4'h9);
    press(4'h8);
    press(4'h7);
    press(4'h6);
    chk("sat_4", 32'(save1), 32'h9876);
    press(4'h5);
    chk("sat_5", 32'(save1), 32'h9876);

    // op overwrite and ignored equals
    press(4'hF);
    press(4'hE);
    chk_all_zero("eq_ignored");
    press(4'h7);
    press(4'hB);
    press(4'hC);
    chk("ovr_op", 32'(op), 32'hC);
    chk("ovr_ds", 32'(display_state), 32'h1);
    chk("ovr_save1", 32'(save1), 32'h0007);
    press(4'hE);
    chk("opsel_eq_ignored", 32'(dbg_state), 32'h1);
    press(4'h2);
    chk("e2_save2", 32'(save2), 32'h0002);
    press(4'hD);
    chk("e2_op_ignored", 32'(op), 32'hC);
    press(4'hE);
    press(4'h5);
    chk("wait_key_ignored", 32'(save2), 32'h0002);
    chk("wait_state", 32'(dbg_state), 32'h3);

    // clear coincident with calc_done in WAIT_RES
    calc_done = 1'b1;
    press(4'hF);
    calc_done = 1'b0;
    chk_all_zero("clr_prio");
    pulse_done();
    chk("clr_late_done", 32'(dbg_state), 32'h0);

    // reset in WAIT_RES
    press(4'h1);
    press(4'hA);
    press(4'h2);
    press(4'hE);
    chk("mid_state", 32'(dbg_state), 32'h3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_all_zero("mid_rst");
    pulse_done();
    chk("mid_late_done", 32'(dbg_state), 32'h0);

    // timeout, with TIMEOUT_CYCLES = 8
    press(4'h1);
    press(4'hB);
    press(4'h2);
    press(4'hE);
    idle(7);
    chk("tmo_7_state", 32'(dbg_state), 32'h3);
    chk("tmo_7_err", 32'(err), 32'h0);
    idle(1);
`ifdef CALC_ENTRY_TIMEOUT_EN
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_ds", 32'(display_state), 32'h3);
    press(4'h6);
    chk("tmo_err_clr", 32'(err), 32'h0);
    chk("tmo_restart", 32'(save1), 32'h0006);
    // calc_done on the timeout cycle wins
    press(4'hA);
    press(4'h1);
    press(4'hE);
    idle(7);
    pulse_done();
    chk("tmo_tie_state", 32'(dbg_state), 32'h4);
    chk("tmo_tie_err", 32'(err), 32'h0);
`else
    chk("notmo_state", 32'(dbg_state), 32'h3);
    chk("notmo_err", 32'(err), 32'h0);
    idle(20);
    chk("notmo_long_state", 32'(dbg_state), 32'h3);
    chk("notmo_long_err", 32'(err), 32'h0);
`endif
    press(4'hF);
    chk_all_zero("final_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
